// File: rtl/adder_stream_accum_if.sv
// Stream-in / result-out bundle for adder_stream_accum.
// Ports: in_valid/in_ready/in_data/in_last operand stream; out_valid/out_ready/out_sum/out_carries/out_count/out_sat result.
// master = producer of operands and consumer of results; slave = the accumulator block.
interface adder_stream_accum_if #(
    parameter int N  = 8,
    parameter int CW = 8,
    parameter int TW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_last;

    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic [CW-1:0] out_carries;
    logic [TW-1:0] out_count;
    logic          out_sat;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_carries, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carries, out_count, out_sat
    );
endinterface

// File: rtl/adder_stream_accum.sv
// Accumulates a burst of operands through an external N-bit adder and reports sum, carry count and term count.
// Latency: beat accepted and summed in the same cycle; result valid the cycle after the last beat.
// Backpressure: in_ready low while a result is held (DONE); result held until out_ready, then one idle bubble.
// Ports: clk, rst_n (async active-low); io (slave modport: operand stream + result);
//        add_a/add_b drive the adder, add_sum/add_cout return from it.
module adder_stream_accum #(
    parameter int N  = 8,
    parameter int CW = 8,
    parameter int TW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_stream_accum_if.slave  io,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CARRY_MAX = '1;
    localparam logic [TW-1:0] TERM_MAX  = '1;

    state_t        state;
    state_t        state_nxt;

    logic [N-1:0]  acc;
    logic [CW-1:0] carry_cnt;
    logic [TW-1:0] term_cnt;
    logic          sat;

    logic          accept;
    logic          carry_sat;
    logic          term_sat;
    logic [CW-1:0] carry_nxt;
    logic [TW-1:0] term_nxt;
    logic          sat_nxt;

    // The adder always sees the live accumulator and the offered operand;
    // its result is only consumed on an accept cycle.
    assign add_a = acc;
    assign add_b = io.in_data;

    assign accept = io.in_valid && io.in_ready;

    // Post-beat counter values. A saturation event is an increment that
    // would have wrapped; the counter sticks at its maximum instead.
    always_comb begin
        carry_sat = add_cout && (carry_cnt == CARRY_MAX);
        term_sat  = (term_cnt == TERM_MAX);
        carry_nxt = carry_sat ? carry_cnt : carry_cnt + CW'(add_cout);
        term_nxt  = term_sat  ? term_cnt  : term_cnt + TW'(1);
        sat_nxt   = sat || carry_sat || term_sat;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = io.in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: both handshake flags come straight from registered state.
    always_comb begin
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: io.in_ready  = 1'b1;
            DONE:        io.out_valid = 1'b1;
            default:     io.in_ready  = 1'b0;
        endcase
    end

    // Running accumulator and counters. On the last beat they clear so the
    // next burst starts from zero while the result registers hold the totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            carry_cnt <= '0;
            term_cnt  <= '0;
            sat       <= 1'b0;
        end else if (accept) begin
            if (io.in_last) begin
                acc       <= '0;
                carry_cnt <= '0;
                term_cnt  <= '0;
                sat       <= 1'b0;
            end else begin
                acc       <= add_sum;
                carry_cnt <= carry_nxt;
                term_cnt  <= term_nxt;
                sat       <= sat_nxt;
            end
        end
    end

    // Result registers load only on the last beat and otherwise hold,
    // including after the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_sum     <= '0;
            io.out_carries <= '0;
            io.out_count   <= '0;
            io.out_sat     <= 1'b0;
        end else if (accept && io.in_last) begin
            io.out_sum     <= add_sum;
            io.out_carries <= carry_nxt;
            io.out_count   <= term_nxt;
            io.out_sat     <= sat_nxt;
        end
    end

endmodule

// File: doc/adder_stream_accum.md
Name: adder_stream_accum

Overview:
- Sequential controller wrapped around the N-bit combinational adder (ports A, B, Sum, Cout).
- Accepts a valid/ready stream of N-bit operands and drives the adder with A = running accumulator, B = incoming operand.
- Registers Sum back into the accumulator and counts Cout events.
- On the last beat of a burst, presents the total, carry count and term count on a valid/ready result port.

Parameters:
- N, 8, operand/accumulator width; must match the attached adder's N.
- CW, 8, width of carry-event counter.
- TW, 8, width of term counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  N  operand.
- in_last  input  1  final beat of current burst.
- add_a  output  N  to adder A; equals acc register.
- add_b  output  N  to adder B; equals in_data.
- add_sum  input  N  from adder Sum.
- add_cout  input  1  from adder Cout.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  N  final accumulator value.
- out_carries  output  CW  number of beats that produced Cout=1 (saturating).
- out_count  output  TW  number of beats in burst (saturating).
- out_sat  output  1  out_carries or out_count saturated during burst.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, carry_cnt=0, term_cnt=0, sat=0, out_valid=0, out_sum=0, out_carries=0, out_count=0, out_sat=0; in_ready=1 once released.
- States:
  - IDLE: no burst in progress, acc=0.
  - ACCUM: at least one non-last beat taken.
  - DONE: result held.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE. No skid buffer.
- Beat accepted when in_valid & in_ready, same cycle. Adder path is combinational; no added latency.
- Next-cycle updates on each accepted beat:
  - acc <= add_sum.
  - carry_cnt += add_cout, saturating at 2^CW-1.
  - term_cnt += 1, saturating at 2^TW-1.
  - sat is set by any saturation event.
- Non-last accept: IDLE/ACCUM -> ACCUM.
- Last accept (in_last=1):
  - Result registers load the post-beat values (add_sum, updated counters, updated sat).
  - out_valid=1 on the next cycle; state -> DONE.
  - acc, carry_cnt, term_cnt and sat clear to 0 in the same edge.
- Single-beat burst (in_last on first beat) is legal: result = 0 + in_data.
- DONE:
  - out_* hold stable while out_valid=1 and out_ready=0.
  - When out_valid & out_ready: out_valid -> 0, state -> IDLE next cycle. One-cycle input bubble is required.
- Result registers keep their last values after the handshake; only out_valid drops.
- in_valid with in_ready=0 is ignored; data is not captured.
- Wrap-around: acc is N bits modulo 2^N; overflow is reported only via out_carries.
- Reset asserted mid-burst or in DONE: immediate return to reset values. A pending result is discarded.
- add_a/add_b are driven in all states; the adder output is only used on accept cycles.

Test Plan:
- Burst 5, 3, 10(last), out_ready=1 -> out_valid for 1 cycle, out_sum=18, out_carries=0, out_count=3, out_sat=0.
- Burst 8'hFF, 8'h01(last) -> out_sum=8'h00, out_carries=1, out_count=2. Then burst 8'hAA(last) alone -> out_sum=8'hAA, out_carries=0, out_count=1 (acc cleared).
- Backpressure: burst 100, 28(last) with out_ready=0 for 3 cycles:
  - outputs hold 128/0/2 and in_ready=0 throughout.
  - in_valid beats offered meanwhile are not counted.
  - Release out_ready -> IDLE next cycle.
- CW=2 override, five beats of 8'hFF(last on 5th):
  - carries would reach 4 -> out_carries=3, out_sat=1.
  - out_sum=8'hFB, out_count=5.
- Reset mid-burst: accept 20, 10, assert rst_n=0 between clock edges -> all outputs 0 immediately. After release, burst 8'h0F, 8'h01(last) -> out_sum=8'h10, out_count=2 (no residue).
- Back-to-back bursts with in_valid held high:
  - in_ready drops exactly for the DONE cycle(s).
  - Second burst's result is independent of the first.
